// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg -- configurable UART transmitter with an internal baud divider.
//
// Frame: START(0), DATA_WIDTH data bits LSB first, optional parity bit, then
// one or two STOP bits(1). Every bit holds serial_o for baud_div+1 clocks.
// Data and all frame configuration are latched when a word is accepted, so
// input changes during a frame do not affect that frame.
//
// Optional feature (macro UART_TX_BREAK_EN): line-break generation. The
// break_i input, taken in IDLE, drives the line low until it is released.
// The line then holds one mark bit period before the block returns to IDLE.
// Without the macro, break_i is ignored.
//
// Handshake: a word transfers on a rising edge where tx_valid_i and
// tx_ready_o are both high. tx_ready_o is high only in IDLE, and low while a
// break is requested. The host holds tx_valid_i and tx_data_i until the
// transfer. tx_valid_i seen while busy is ignored.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   tx_data_i      word to send (DATA_WIDTH bits)
//   tx_valid_i     host has a word
//   tx_ready_o     block can accept a word (combinational from state)
//   baud_div_i     bit period minus one, in clocks
//   parity_mode_i  00 none, 01 even, 10 odd, 11 none
//   stop2_i        0 = one stop bit, 1 = two stop bits
//   break_i        line-break request (used only with UART_TX_BREAK_EN)
//   serial_o       TX line, idle high, registered
//   busy_o         frame or break in progress, registered
//   tx_done_o      one-cycle pulse at frame end, registered
module uart_tx_cfg #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    input  logic [DIV_WIDTH-1:0]  baud_div_i,
    input  logic [1:0]            parity_mode_i,
    input  logic                  stop2_i,
    input  logic                  break_i,
    output logic                  serial_o,
    output logic                  busy_o,
    output logic                  tx_done_o
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

`ifdef UART_TX_BREAK_EN
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_DATA     = 3'd2,
        S_PARITY   = 3'd3,
        S_STOP     = 3'd4,
        S_BREAK    = 3'd5,
        S_BRK_MARK = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`endif

    state_t                state_q;
    logic [DIV_WIDTH-1:0]  div_q;        // latched bit period minus one
    logic [DIV_WIDTH-1:0]  cnt_q;        // counts div_q..0 within one bit
    logic [DATA_WIDTH-1:0] shift_q;      // remaining data bits, LSB next out
    logic [CW-1:0]         bit_cnt_q;    // index of the data bit on the line
    logic                  par_en_q;
    logic                  par_bit_q;
    logic                  stop2_q;
    logic                  stop_left_q;  // a second stop bit still follows
    logic                  bit_end;

    assign bit_end = (cnt_q == '0);

`ifdef UART_TX_BREAK_EN
    assign tx_ready_o = (state_q == S_IDLE) && !break_i;
`else
    assign tx_ready_o = (state_q == S_IDLE);
    logic unused_break;
    assign unused_break = break_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            cnt_q       <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
            stop2_q     <= 1'b0;
            stop_left_q <= 1'b0;
            serial_o    <= 1'b1;
            busy_o      <= 1'b0;
            tx_done_o   <= 1'b0;
        end else begin
            tx_done_o <= 1'b0;
            // Default: count down inside a bit. Bit-end handling below
            // reloads the counter when a new bit begins.
            if (!bit_end) cnt_q <= cnt_q - DIV_WIDTH'(1);

            case (state_q)
                S_IDLE: begin
                    serial_o <= 1'b1;
                    busy_o   <= 1'b0;
`ifdef UART_TX_BREAK_EN
                    // A break request takes priority over a pending word.
                    if (break_i) begin
                        div_q    <= baud_div_i;
                        serial_o <= 1'b0;
                        busy_o   <= 1'b1;
                        state_q  <= S_BREAK;
                    end else
`endif
                    if (tx_valid_i) begin
                        shift_q   <= tx_data_i;
                        div_q     <= baud_div_i;
                        cnt_q     <= baud_div_i;
                        par_en_q  <= (parity_mode_i == 2'b01) || (parity_mode_i == 2'b10);
                        par_bit_q <= (^tx_data_i) ^ (parity_mode_i == 2'b10);
                        stop2_q   <= stop2_i;
                        serial_o  <= 1'b0;
                        busy_o    <= 1'b1;
                        state_q   <= S_START;
                    end
                end

                S_START: begin
                    if (bit_end) begin
                        cnt_q     <= div_q;
                        serial_o  <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_cnt_q <= '0;
                        state_q   <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (bit_end) begin
                        cnt_q <= div_q;
                        if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
                            if (par_en_q) begin
                                serial_o <= par_bit_q;
                                state_q  <= S_PARITY;
                            end else begin
                                serial_o    <= 1'b1;
                                stop_left_q <= stop2_q;
                                state_q     <= S_STOP;
                            end
                        end else begin
                            serial_o  <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_cnt_q <= bit_cnt_q + CW'(1);
                        end
                    end
                end

                S_PARITY: begin
                    if (bit_end) begin
                        cnt_q       <= div_q;
                        serial_o    <= 1'b1;
                        stop_left_q <= stop2_q;
                        state_q     <= S_STOP;
                    end
                end

                S_STOP: begin
                    if (bit_end) begin
                        if (stop_left_q) begin
                            cnt_q       <= div_q;
                            stop_left_q <= 1'b0;
                        end else begin
                            busy_o    <= 1'b0;
                            tx_done_o <= 1'b1;
                            state_q   <= S_IDLE;
                        end
                    end
                end

`ifdef UART_TX_BREAK_EN
                S_BREAK: begin
                    if (!break_i) begin
                        cnt_q    <= div_q;
                        serial_o <= 1'b1;
                        state_q  <= S_BRK_MARK;
                    end
                end

                S_BRK_MARK: begin
                    if (bit_end) begin
                        busy_o  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
`endif

                default: begin
                    serial_o <= 1'b1;
                    busy_o   <= 1'b0;
                    cnt_q    <= '0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg -- directed testbench for uart_tx_cfg (DATA_WIDTH=8).
// Expected line patterns are hand-written bit strings, first bit on the line first.
module tb_uart_tx_cfg;

    localparam int DW  = 8;
    localparam int DVW = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0]  tx_data = '0;
    logic           tx_valid = 1'b0;
    logic           tx_ready;
    logic [DVW-1:0] baud_div = '0;
    logic [1:0]     parity_mode = 2'b00;
    logic           stop2 = 1'b0;
    logic           brk = 1'b0;
    logic           serial;
    logic           busy;
    logic           tx_done;

    uart_tx_cfg #(.DATA_WIDTH(DW), .DIV_WIDTH(DVW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
        .tx_ready_o   (tx_ready),
        .baud_div_i   (baud_div),
        .parity_mode_i(parity_mode),
        .stop2_i      (stop2),
        .break_i      (brk),
        .serial_o     (serial),
        .busy_o       (busy),
        .tx_done_o    (tx_done)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [0:0] exp_q[$];
    int last_done_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- driver tasks ----------------
    // Call at a negedge; returns just after the accept edge.
    task automatic start_frame(input logic [7:0] d, input int div,
                               input logic [1:0] par, input logic s2);
        tx_data     = d;
        baud_div    = DVW'(div);
        parity_mode = par;
        stop2       = s2;
        tx_valid    = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Checks the line for every clock of the frame, then the end-of-frame state.
    task automatic expect_frame(input string bits, input int div, input string tag);
        logic e;
        for (int i = 0; i < bits.len(); i++) exp_q.push_back(bits[i] == 8'h31);
        for (int b = 0; b < bits.len(); b++) begin
            e = exp_q.pop_front();
            for (int k = 0; k <= div; k++) begin
                @(negedge clk);
                check({tag, ".serial"}, 32'(serial), 32'(e));
                check({tag, ".busy"}, 32'(busy), 32'd1);
                check({tag, ".done_low"}, 32'(tx_done), 32'd0);
            end
        end
        @(negedge clk);
        check({tag, ".done"}, 32'(tx_done), 32'd1);
        check({tag, ".busy_end"}, 32'(busy), 32'd0);
        check({tag, ".serial_end"}, 32'(serial), 32'd1);
        check({tag, ".ready_end"}, 32'(tx_ready), 32'd1);
        last_done_cyc = cyc;
    endtask

    task automatic expect_idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({tag, ".serial"}, 32'(serial), 32'd1);
            check({tag, ".busy"}, 32'(busy), 32'd0);
            check({tag, ".done"}, 32'(tx_done), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int e0;
        int d0;

        repeat (3) @(negedge clk);
        check("rst.serial", 32'(serial), 32'd1);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(tx_done), 32'd0);
        check("rst.ready", 32'(tx_ready), 32'd1);
        rst_n = 1'b1;

        // Idle with no valid for 100 clocks
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle.serial", 32'(serial), 32'd1);
            check("idle.busy", 32'(busy), 32'd0);
            check("idle.ready", 32'(tx_ready), 32'd1);
        end

        // 0xA5, div 3, even parity, one stop: parity 0, 44 clocks
        start_frame(8'hA5, 3, 2'b01, 1'b0);
        e0 = cyc;
        tx_valid = 1'b0;
        expect_frame("01010010101", 3, "a5_even");
        check("a5_even.len", 32'(last_done_cyc - e0), 32'd44);

        // 0x07, div 3, odd parity, two stops: parity 0, 48 clocks
        @(negedge clk);
        start_frame(8'h07, 3, 2'b10, 1'b1);
        e0 = cyc;
        tx_valid = 1'b0;
        expect_frame("011100000011", 3, "07_odd");
        check("07_odd.len", 32'(last_done_cyc - e0), 32'd48);

        // Back-to-back, div 0, no parity: 0x00 then 0xFF with valid held
        @(negedge clk);
        start_frame(8'h00, 0, 2'b00, 1'b0);
        tx_data = 8'hFF;
        expect_frame("0000000001", 0, "b2b0");
        d0 = last_done_cyc;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        expect_frame("0111111111", 0, "b2b1");
        check("b2b.gap", 32'(last_done_cyc - d0), 32'd11);

        // Latching: 0x3C, div 1, even parity; inputs change a cycle after
        // accept and valid stays high while busy.
        @(negedge clk);
        start_frame(8'h3C, 1, 2'b01, 1'b0);
        fork
            expect_frame("00011110001", 1, "latch");
            begin
                @(posedge clk);
                #1;
                tx_data     = 8'hFF;
                baud_div    = 16'd5;
                parity_mode = 2'b10;
                stop2       = 1'b1;
                repeat (5) @(posedge clk);
                #1;
                tx_valid = 1'b0;
            end
        join
        expect_idle(12, "no_second");

        // Reset in mid-frame
        start_frame(8'hA5, 3, 2'b01, 1'b0);
        tx_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.serial", 32'(serial), 32'd1);
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.done", 32'(tx_done), 32'd0);
        check("midrst.ready", 32'(tx_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        expect_idle(12, "after_rst");

`ifdef UART_TX_BREAK_EN
        // Break for 20 clocks at div 3, then a 4-clock mark
        baud_div = 16'd3;
        brk = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("brk.serial", 32'(serial), 32'd0);
            check("brk.busy", 32'(busy), 32'd1);
            check("brk.ready", 32'(tx_ready), 32'd0);
            check("brk.done", 32'(tx_done), 32'd0);
        end
        brk = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mark.serial", 32'(serial), 32'd1);
            check("mark.busy", 32'(busy), 32'd1);
            check("mark.done", 32'(tx_done), 32'd0);
            check("mark.ready", 32'(tx_ready), 32'd0);
        end
        @(negedge clk);
        check("brk_end.ready", 32'(tx_ready), 32'd1);
        check("brk_end.busy", 32'(busy), 32'd0);
        check("brk_end.done", 32'(tx_done), 32'd0);
        check("brk_end.serial", 32'(serial), 32'd1);
`else
        // Without the break feature, break_i has no effect
        brk = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("nobrk.serial", 32'(serial), 32'd1);
            check("nobrk.busy", 32'(busy), 32'd0);
            check("nobrk.ready", 32'(tx_ready), 32'd1);
        end
        brk = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, successor to the fixed 8N2 transmitter with its external baud pulse.
- Internal baud divider; no external baud input.
- Valid/ready byte interface.
- Runtime-selectable parity (none/even/odd) and stop bits (1/2).
- Sits between a host-side byte source (register file or FIFO) and the serial pin.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9), sent LSB first
DIV_WIDTH, 16, width of baud divisor input

Ports:
clk_i  in  1  clock, all logic rising-edge
rst_ni  in  1  asynchronous active-low reset
tx_data_i  in  DATA_WIDTH  word to send, captured on accept
tx_valid_i  in  1  host has a word
tx_ready_o  out  1  block can accept a word (high only in IDLE)
baud_div_i  in  DIV_WIDTH  bit period minus one, in clocks; captured on accept
parity_mode_i  in  2  00 none, 01 even, 10 odd, 11 treated as none; captured on accept
stop2_i  in  1  0 = one stop bit, 1 = two stop bits; captured on accept
break_i  in  1  line-break request (see Optional Feature)
serial_o  out  1  TX line, idle high, registered
busy_o  out  1  frame in progress, registered
tx_done_o  out  1  one-cycle pulse at frame end, registered

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; serial_o=1, busy_o=0, tx_done_o=0, tx_ready_o=1.
  - Divider and bit counters cleared.
  - Reset mid-frame aborts the frame immediately; the line returns high with no glitch low.
- States: IDLE, START, DATA, PARITY, STOP (plus BREAK, BRK_MARK when the macro is set).
- tx_ready_o = (state==IDLE) and not break request; combinational from state.
- Accept: at the edge where tx_valid_i & tx_ready_o:
  - data, div, parity and stop config latched.
  - serial_o<=0, busy_o<=1, state->START.
  - Config/data changes after accept do not affect the current frame.
- Bit timing:
  - Every bit holds serial_o for exactly baud_div+1 clocks (div counter counts div..0).
  - baud_div_i=0 gives 1 clock per bit.
- Order: START(0) -> DATA bits LSB first -> PARITY (only if mode 01/10) -> STOP (1 or 2 bits of 1).
- Parity:
  - Even: XOR of data bits.
  - Odd: inverted XOR of data bits.
- Frame length F = (1 + DATA_WIDTH + P + S)*(div+1) clocks; P in {0,1}, S in {1,2}.
- Completion: at edge E0+F (E0 = accept edge):
  - state->IDLE, busy_o<=0, tx_done_o<=1 for one cycle; serial_o stays 1.
  - busy_o is high for exactly F cycles.
- Back-to-back: with tx_valid_i held, the next accept is at E0+F+1, giving exactly one idle-high clock between frames.
- tx_valid_i while busy: ignored, no capture; the host must hold it until tx_ready_o.
- Illegal state encoding: recover to IDLE with serial_o=1.

Optional Feature:
UART_TX_BREAK_EN
- Defined:
  - break_i high while in IDLE (checked before tx_valid_i) -> BREAK: serial_o=0, busy_o=1, tx_ready_o=0 for as long as break_i stays high.
  - On break_i low -> BRK_MARK: serial_o=1 for one bit period (div+1 clocks, div sampled at break entry), then IDLE.
  - No tx_done_o pulse for a break.
  - break_i during a frame is deferred until the frame ends.
- Not defined: break_i is ignored, BREAK/BRK_MARK states are absent, and behaviour is identical to the baseline.

Test Plan:
- Reset then idle, no valid -> serial_o=1, busy_o=0, tx_ready_o=1 for 100 clocks; assert rst_ni low mid-frame -> serial_o=1 and busy_o=0 immediately, no tx_done_o.
- DATA_WIDTH=8, div=3, parity 01, stop2=0, data 0xA5:
  - serial_o per 4-clock bit: 0,1,0,1,0,0,1,0,1,0(parity),1.
  - busy_o high 44 clocks; tx_done_o pulse at E0+44.
- Same with parity 10, stop2=1, data 0x07 -> parity bit 0; frame 12 bits = 48 clocks; two stop bits high.
- div=0, parity 00, tx_valid_i held for 0x00 then 0xFF -> 10-clock frames; exactly 1 idle-high clock between them; two tx_done_o pulses 11 clocks apart.
- Change baud_div_i, parity_mode_i and tx_data_i one cycle after accept -> frame uses the latched values; tx_valid_i pulsed while busy -> no second frame.
- UART_TX_BREAK_EN, div=3: break_i high 20 clocks from IDLE -> serial_o=0 for 20 clocks, then high 4 clocks with busy_o=1, then tx_ready_o=1; no tx_done_o.
